// File: rtl/sprite_pixel_fetch_if.sv
// Signal bundle between the sprite fetch stage, its beam/player source and the sprite ROM.
// The DUT takes the slave modport; the driver of beam, player and ROM data takes the master.
interface sprite_pixel_fetch_if;
    logic        frame_tick;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic        moving;
    logic        jump;
    logic        facing_left;
    logic [20:0] read_address;
    logic [4:0]  rom_data;
    logic        pixel_on;
    logic [4:0]  pixel_index;
    logic [3:0]  anim_frame;

    modport master (
        output frame_tick, draw_x, draw_y, player_x, player_y,
               moving, jump, facing_left, rom_data,
        input  read_address, pixel_on, pixel_index, anim_frame
    );

    modport slave (
        input  frame_tick, draw_x, draw_y, player_x, player_y,
               moving, jump, facing_left, rom_data,
        output read_address, pixel_on, pixel_index, anim_frame
    );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Player sprite animation state and ROM address generation with a fixed 2-clock beam-to-pixel latency.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_pixel_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 64,
    parameter int BASE_ADDR   = 0,
    parameter int RUN_FRAMES  = 4,
    parameter int JUMP_FRAMES = 2,
    parameter int ANIM_DIV    = 6,
    parameter int TRANSP      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_pixel_fetch_if.slave  bus
);
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {STAND, RUN, JUMP} state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [3:0]       step_reg, step_next;
    logic [3:0]       anim_frame_reg, anim_frame_next;
    logic             div_wrap, jump_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= STAND;
            div_reg        <= '0;
            step_reg       <= '0;
            anim_frame_reg <= '0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            step_reg       <= step_next;
            anim_frame_reg <= anim_frame_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        step_next  = step_reg;
        div_wrap   = (div_reg == DIV_W'(ANIM_DIV - 1));
        jump_last  = div_wrap && (step_reg == 4'(JUMP_FRAMES - 1));
        if (bus.frame_tick) begin
            case (state_reg)
                STAND: begin
                    if (bus.jump)        state_next = JUMP;
                    else if (bus.moving) state_next = RUN;
                end
                RUN: begin
                    if (bus.jump)         state_next = JUMP;
                    else if (!bus.moving) state_next = STAND;
                end
                JUMP: begin
                    // Jump runs to completion; inputs only matter on its final step.
                    if (jump_last) state_next = bus.moving ? RUN : STAND;
                end
                default: state_next = STAND;
            endcase

            if (state_next != state_reg) begin
                div_next  = '0;
                step_next = '0;
            end else if (div_wrap) begin
                div_next = '0;
                case (state_reg)
                    RUN:     step_next = (step_reg == 4'(RUN_FRAMES - 1)) ? 4'd0 : step_reg + 4'd1;
                    JUMP:    step_next = step_reg + 4'd1;
                    default: step_next = 4'd0;
                endcase
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    always_comb begin
        anim_frame_next = 4'd0;
        case (state_next)
            RUN:     anim_frame_next = 4'd1 + step_next;
            JUMP:    anim_frame_next = 4'(RUN_FRAMES + 1) + step_next;
            default: anim_frame_next = 4'd0;
        endcase
    end

    // Box test is done in 11 bits so a player near x=1023 cannot wrap onto x=0.
    logic [10:0] col, row, col_eff;
    logic        inbox;
    logic [20:0] addr_calc;
    logic [20:0] read_address_reg;
    logic        inbox_stage_reg [2];
    logic        pixel_on;

    assign col   = {1'b0, bus.draw_x} - {1'b0, bus.player_x};
    assign row   = {1'b0, bus.draw_y} - {1'b0, bus.player_y};
    assign inbox = (bus.draw_x >= bus.player_x) && (col < 11'(SPR_W)) &&
                   (bus.draw_y >= bus.player_y) && (row < 11'(SPR_H));

`ifdef SPRITE_MIRROR_EN
    assign col_eff = bus.facing_left ? 11'(SPR_W - 1) - col : col;
`else
    logic unused_facing;
    assign col_eff       = col;
    assign unused_facing = bus.facing_left;
`endif

    assign addr_calc = 21'(BASE_ADDR)
                     + 21'(anim_frame_reg) * 21'(SPR_W * SPR_H)
                     + 21'(row) * 21'(SPR_W)
                     + 21'(col_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) read_address_reg <= '0;
        else        read_address_reg <= inbox ? addr_calc : 21'd0;
    end

    // Stage 0 aligns with the registered address, stage 1 with the ROM's registered data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inbox_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) inbox_stage_reg[gi] <= 1'b0;
                    else        inbox_stage_reg[gi] <= inbox;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) inbox_stage_reg[gi] <= 1'b0;
                    else        inbox_stage_reg[gi] <= inbox_stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign pixel_on         = inbox_stage_reg[1] && (bus.rom_data != 5'(TRANSP));
    assign bus.pixel_on     = pixel_on;
    assign bus.pixel_index  = pixel_on ? bus.rom_data : 5'd0;
    assign bus.read_address = read_address_reg;
    assign bus.anim_frame   = anim_frame_reg;
endmodule
